alu_op_arbiter: RTL and testbench

- Sequencer and arbiter that shares one combinational 4-bit, four-function ALU (add 00, sub 01, AND 10, XOR 11) between two requesters.
- Arbitrates round-robin and latches the winner's operands and function select into operand registers.
- Drives the ALU, waits a programmable settle time, then captures result, carry and overflow into output registers and acknowledges the winner.
- Sits between the processor control unit or front-panel logic and the shared ALU datapath.

---
 rtl/alu_op_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_op_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_op_arbiter                                                         |
// | Round-robin sequencer sharing one 4-bit ALU between two requesters.    |
// | Optional feature macro: STICKY_OVR_EN (adds ovr_clr / ovr_sticky).     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module alu_op_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [1:0] req,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic [1:0] S0,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  input  logic [1:0] S1,
`ifdef STICKY_OVR_EN
  input  logic       ovr_clr,
  output logic       ovr_sticky,
`endif
  output logic [1:0] ack,
  output logic       grant,
  output logic       busy,
  output logic [3:0] R_out,
  output logic       Cout_out,
  output logic       OVR_out,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_S,
  input  logic [3:0] alu_R,
  input  logic       alu_Cout,
  input  logic       alu_OVR
);

  localparam int c_exec_eff = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int c_cnt_w    = (c_exec_eff > 1) ? $clog2(c_exec_eff) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_exec_eff - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_grant;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_a;
  logic [3:0]           r_b;
  logic [1:0]           r_s;
  logic [3:0]           r_r;
  logic                 r_cout;
  logic                 r_ovr;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_win;
  logic [1:0]           w_ack;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_win        = r_grant;
    w_ack        = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          w_load       = 1'b1;
          // On a tie the previous winner yields.
          w_win        = (req == 2'b11) ? ~r_grant : req[1];
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_ack        = r_grant ? 2'b10 : 2'b01;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b1;
      r_cnt   <= '0;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_s     <= 2'd0;
      r_r     <= 4'd0;
      r_cout  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_grant <= w_win;
        r_a     <= w_win ? A1 : A0;
        r_b     <= w_win ? B1 : B0;
        r_s     <= w_win ? S1 : S0;
        r_cnt   <= c_cnt_load;
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - c_cnt_one;
      end
      if (w_capture) begin
        r_r    <= alu_R;
        r_cout <= alu_Cout;
        r_ovr  <= alu_OVR;
      end
    end
  end

`ifdef STICKY_OVR_EN
  logic r_ovr_sticky;

  // A setting capture takes priority over a simultaneous clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ovr_sticky <= 1'b0;
    end else if (w_capture && alu_OVR) begin
      r_ovr_sticky <= 1'b1;
    end else if (ovr_clr) begin
      r_ovr_sticky <= 1'b0;
    end
  end

  assign ovr_sticky = r_ovr_sticky;
`endif

  assign ack      = w_ack;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign R_out    = r_r;
  assign Cout_out = r_cout;
  assign OVR_out  = r_ovr;
  assign alu_A    = r_a;
  assign alu_B    = r_b;
  assign alu_S    = r_s;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
`default_nettype none
// Bench for alu_op_arbiter: two instances (EXEC_CYCLES=1 and 3) checked every cycle
// against a transaction-level model, plus hand-computed literal expectations.
module tb_alu_op_arbiter;

  localparam int E0 = 1;
  localparam int E1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b1;
  logic [1:0] req_v [2];
  logic [3:0] A0, B0, A1, B1;
  logic [1:0] S0, S1;

  logic [1:0] ack_v [2];
  logic       grant_v [2];
  logic       busy_v [2];
  logic [3:0] rout_v [2];
  logic       cout_v [2];
  logic       ovr_v [2];
  logic [3:0] aa_v [2];
  logic [3:0] ab_v [2];
  logic [1:0] as_v [2];
  logic [3:0] ar_v [2];
  logic       ac_v [2];
  logic       ao_v [2];
`ifdef STICKY_OVR_EN
  logic       ovr_clr = 1'b0;
  logic       sticky_v [2];
`endif

  int total = 0;
  int bad   = 0;
  logic run_chk = 1'b0;

  // Reference ALU: {cout, ovr, result}
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    logic [4:0] t;
    logic [3:0] r;
    logic c, o;
    c = 1'b0; o = 1'b0;
    case (s)
      2'b00: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4];
                   o = (a[3] == b[3]) && (r[3] != a[3]); end
      2'b01: begin r = a - b; c = (a >= b);
                   o = (a[3] != b[3]) && (r[3] != a[3]); end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    return {c, o, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign {ac_v[g], ao_v[g], ar_v[g]} = alu_f(aa_v[g], ab_v[g], as_v[g]);
  end

  alu_op_arbiter #(.EXEC_CYCLES(E0)) u_dut1 (
    .Clock(clk), .Resetn(rstn), .req(req_v[0]),
    .A0(A0), .B0(B0), .S0(S0), .A1(A1), .B1(B1), .S1(S1),
`ifdef STICKY_OVR_EN
    .ovr_clr(ovr_clr), .ovr_sticky(sticky_v[0]),
`endif
    .ack(ack_v[0]), .grant(grant_v[0]), .busy(busy_v[0]),
    .R_out(rout_v[0]), .Cout_out(cout_v[0]), .OVR_out(ovr_v[0]),
    .alu_A(aa_v[0]), .alu_B(ab_v[0]), .alu_S(as_v[0]),
    .alu_R(ar_v[0]), .alu_Cout(ac_v[0]), .alu_OVR(ao_v[0])
  );

  alu_op_arbiter #(.EXEC_CYCLES(E1)) u_dut3 (
    .Clock(clk), .Resetn(rstn), .req(req_v[1]),
    .A0(A0), .B0(B0), .S0(S0), .A1(A1), .B1(B1), .S1(S1),
`ifdef STICKY_OVR_EN
    .ovr_clr(ovr_clr), .ovr_sticky(sticky_v[1]),
`endif
    .ack(ack_v[1]), .grant(grant_v[1]), .busy(busy_v[1]),
    .R_out(rout_v[1]), .Cout_out(cout_v[1]), .OVR_out(ovr_v[1]),
    .alu_A(aa_v[1]), .alu_B(ab_v[1]), .alu_S(as_v[1]),
    .alu_R(ar_v[1]), .alu_Cout(ac_v[1]), .alu_OVR(ao_v[1])
  );

  task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got=%h expected=%h at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Model: an operation occupies EXEC+1 cycles after the granting edge;
  // results land at the end of the EXEC phase, ack is the final cycle.
  int         m_left [2];
  logic       m_grant [2];
  logic [3:0] m_a [2], m_b [2], m_r [2];
  logic [1:0] m_s [2];
  logic       m_c [2], m_o [2], m_st [2];
  logic [5:0] m_res;
  logic       m_cap;

  always begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0; m_grant[k] = 1'b1;
        m_a[k] = 4'd0; m_b[k] = 4'd0; m_s[k] = 2'd0;
        m_r[k] = 4'd0; m_c[k] = 1'b0; m_o[k] = 1'b0; m_st[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_cap = 1'b0;
        if (m_left[k] == 0) begin
          if (req_v[k] != 2'b00) begin
            m_grant[k] = (req_v[k] == 2'b11) ? ~m_grant[k] : req_v[k][1];
            m_a[k] = m_grant[k] ? A1 : A0;
            m_b[k] = m_grant[k] ? B1 : B0;
            m_s[k] = m_grant[k] ? S1 : S0;
            m_left[k] = ((k == 0) ? E0 : E1) + 1;
          end
        end else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_res = alu_f(m_a[k], m_b[k], m_s[k]);
            {m_c[k], m_o[k], m_r[k]} = m_res;
            m_cap = 1'b1;
          end
        end
`ifdef STICKY_OVR_EN
        if (m_cap && m_o[k]) m_st[k] = 1'b1;
        else if (ovr_clr)    m_st[k] = 1'b0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int k = 0; k < 2; k++) begin
        chk("ack",   k, {6'd0, ack_v[k]}, (m_left[k] == 1) ? (m_grant[k] ? 8'h2 : 8'h1) : 8'h0);
        chk("busy",  k, {7'd0, busy_v[k]}, {7'd0, (m_left[k] != 0)});
        chk("grant", k, {7'd0, grant_v[k]}, {7'd0, m_grant[k]});
        chk("R_out", k, {4'd0, rout_v[k]}, {4'd0, m_r[k]});
        chk("flags", k, {6'd0, cout_v[k], ovr_v[k]}, {6'd0, m_c[k], m_o[k]});
        chk("alu_in", k, {aa_v[k], ab_v[k]}, {m_a[k], m_b[k]});
        chk("alu_S", k, {6'd0, as_v[k]}, {6'd0, m_s[k]});
`ifdef STICKY_OVR_EN
        chk("sticky", k, {7'd0, sticky_v[k]}, {7'd0, m_st[k]});
`endif
      end
    end
  end

  task automatic wait_ack(input int k, input logic [1:0] exp, input int exp_edges, input string nm);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (ack_v[k] != 2'b00) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s dut%0d: no ack within 20 cycles, expected ack=%b", nm, k, exp);
    end else begin
      chk({nm, "_ack"}, k, {6'd0, ack_v[k]}, {6'd0, exp});
      chk({nm, "_lat"}, k, 8'(n), 8'(exp_edges));
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, {7'd0, busy_v[k]}, 8'h0);
      chk("rst_ack", k, {6'd0, ack_v[k]}, 8'h0);
      chk("rst_grant", k, {7'd0, grant_v[k]}, 8'h1);
      chk("rst_R", k, {rout_v[k], cout_v[k], ovr_v[k], 2'b00}, 8'h0);
      chk("rst_alu", k, {aa_v[k], ab_v[k]}, 8'h0);
    end
    step();
    rstn = 1'b1;
  endtask

  initial begin
    req_v[0] = 2'b00; req_v[1] = 2'b00;
    A0 = 4'd0; B0 = 4'd0; S0 = 2'd0; A1 = 4'd0; B1 = 4'd0; S1 = 2'd0;
    #2 rstn = 1'b0;
    #1;
    run_chk = 1'b1;
    step();
    rstn = 1'b1;

    // 5 + 3 on requester 0
    A0 = 4'h5; B0 = 4'h3; S0 = 2'b00; req_v[0] = 2'b01;
    wait_ack(0, 2'b01, 2, "add53");
    chk("add53_R", 0, {4'd0, rout_v[0]}, 8'h08);
    chk("add53_flags", 0, {6'd0, cout_v[0], ovr_v[0]}, 8'h01);
    #1 req_v[0] = 2'b00;
    @(negedge clk);
    chk("add53_idle", 0, {7'd0, busy_v[0]}, 8'h0);

    // Round robin with both requests held
    do_reset();
    A0 = 4'hF; B0 = 4'h1; S0 = 2'b00; A1 = 4'hC; B1 = 4'hA; S1 = 2'b10;
    req_v[0] = 2'b11;
    wait_ack(0, 2'b01, 2, "rr1");
    chk("rr1_R", 0, {4'd0, rout_v[0]}, 8'h00);
    chk("rr1_C", 0, {7'd0, cout_v[0]}, 8'h01);
    wait_ack(0, 2'b10, 3, "rr2");
    chk("rr2_R", 0, {4'd0, rout_v[0]}, 8'h08);
    wait_ack(0, 2'b01, 3, "rr3");
    #1 req_v[0] = 2'b00;

    // Long execution, operand changed mid-operation
    step();
    A1 = 4'h6; B1 = 4'h3; S1 = 2'b11; req_v[1] = 2'b10;
    step();
    A1 = 4'h0;
    wait_ack(1, 2'b10, 3, "xor63");
    chk("xor63_R", 1, {4'd0, rout_v[1]}, 8'h05);
    chk("xor63_A", 1, {4'd0, aa_v[1]}, 8'h06);
    #1 req_v[1] = 2'b00;

    // Reset during EXEC, request held through it
    step();
    A0 = 4'h9; B0 = 4'h4; S0 = 2'b00; req_v[1] = 2'b01;
    step();
    chk("mid_busy", 1, {7'd0, busy_v[1]}, 8'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 1, {7'd0, busy_v[1]}, 8'h0);
    chk("mid_rst_ack", 1, {6'd0, ack_v[1]}, 8'h0);
    chk("mid_rst_R", 1, {4'd0, rout_v[1]}, 8'h0);
    chk("mid_rst_A", 1, {4'd0, aa_v[1]}, 8'h0);
    step();
    rstn = 1'b1;
    wait_ack(1, 2'b01, 4, "restart");
    chk("restart_R", 1, {4'd0, rout_v[1]}, 8'h0D);
    #1 req_v[1] = 2'b00;

    // Request dropped right after grant
    step();
    A0 = 4'h2; B0 = 4'h9; S0 = 2'b01; req_v[0] = 2'b01;
    step();
    req_v[0] = 2'b00;
    wait_ack(0, 2'b01, 1, "drop");
    chk("drop_R", 0, {4'd0, rout_v[0]}, 8'h09);
    chk("drop_V", 0, {7'd0, ovr_v[0]}, 8'h01);
    @(negedge clk);
    chk("drop_idle", 0, {7'd0, busy_v[0]}, 8'h0);

`ifdef STICKY_OVR_EN
    do_reset();
    A0 = 4'h7; B0 = 4'h1; S0 = 2'b00; req_v[0] = 2'b01;
    wait_ack(0, 2'b01, 2, "st71");
    chk("st71_sticky", 0, {7'd0, sticky_v[0]}, 8'h1);
    #1 req_v[0] = 2'b00;
    step();
    A0 = 4'h1; req_v[0] = 2'b01;
    wait_ack(0, 2'b01, 2, "st11");
    chk("st11_sticky", 0, {7'd0, sticky_v[0]}, 8'h1);
    #1 req_v[0] = 2'b00;
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("stclr_sticky", 0, {7'd0, sticky_v[0]}, 8'h0);
`endif

    step();
    step();
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
